// File: rtl/rca_pipe_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor.
//   G_DEF / STAGES_DEF : default operand width and pipeline depth
//   mode_e             : add/subtract select encoding carried on the 'sub' pin
//   chunk_width()      : width of one carry chunk (G / STAGES)
package rca_pipe_pkg;

  localparam int G_DEF      = 128;
  localparam int STAGES_DEF = 4;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  function automatic int chunk_width(input int g, input int stages);
    return (stages > 0) ? g / stages : g;
  endfunction

endpackage

// File: rtl/rca_pipe_if.sv
// Operation/result bundle of the pipelined adder.
//   in_valid/in_ready   : operation handshake (a, b, cin, sub)
//   out_valid/out_ready : result handshake (sum, carry, ovf)
//   master : producer of operations and consumer of results
//   slave  : the adder itself
interface rca_pipe_if #(
  parameter int G = 128
);
  logic         in_valid;
  logic         in_ready;
  logic [G-1:0] a;
  logic [G-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [G-1:0] sum;
  logic         carry;
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, carry, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, carry, ovf
  );
endinterface

// File: rtl/rca_chunk.sv
// Combinational W-bit ripple-carry adder, one full adder per bit.
//   a, b     : chunk operands
//   ci       : carry into bit 0
//   s        : chunk sum
//   co       : carry out of bit W-1
//   c_msb_in : carry into bit W-1 (used for signed overflow on the top chunk)
module rca_chunk #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb_in
);

  logic rc;

  always_comb begin
    rc       = ci;
    s        = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < W; i++) begin
      c_msb_in = rc;
      s[i]     = a[i] ^ b[i] ^ rc;
      rc       = (a[i] & b[i]) | (rc & (a[i] ^ b[i]));
    end
    co = rc;
  end

endmodule

// File: rtl/rca_pipe.sv
// Pipelined G-bit ripple-carry adder/subtractor, one W-bit carry chunk per stage.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : operation in (a, b, cin, sub) and result out (sum, carry, ovf)
//                with valid/ready on both sides
// Stage k adds chunk k of the operands using the carry registered by stage k-1.
// Operands travel as a rotating word: each stage consumes the low W bits and
// pushes its finished sum slice in at the top, so after STAGES stages the word
// holds the complete sum in natural bit order (skew and de-skew in one register).
module rca_pipe
  import rca_pipe_pkg::*;
#(
  parameter int G      = G_DEF,
  parameter int STAGES = STAGES_DEF
) (
  input logic       clk,
  input logic       rst_n,
  rca_pipe_if.slave bus
);

  localparam int W  = chunk_width(G, STAGES);
  localparam int NB = (STAGES > 1) ? STAGES - 1 : 1;

  if (STAGES < 1 || (G % STAGES) != 0) begin : g_bad_cfg
    $error("rca_pipe: G (%0d) must be a positive multiple of STAGES (%0d)", G, STAGES);
  end

  logic         adv;
  logic [G-1:0] b_eff;
  logic         c0;
  logic [G-1:0] a_q [STAGES];
  logic [G-1:0] b_q [NB];
  logic         c_q [STAGES];
  logic         v_q [STAGES];
  logic         ovf_q;

  // Subtraction as a + ~b + ~cin: an incoming borrow removes the +1.
  assign b_eff = (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
  assign c0    = (bus.sub == MODE_SUB) ? ~bus.cin : bus.cin;

  assign adv          = !v_q[STAGES-1] || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum       = a_q[STAGES-1];
  assign bus.carry     = c_q[STAGES-1];
  assign bus.ovf       = ovf_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [G-1:0] a_src;
    logic [G-1:0] a_nxt;
    logic [W-1:0] b_chunk;
    logic         c_src;
    logic         v_src;
    logic [W-1:0] s;
    logic         co;
    logic         c_msb;

    if (k == 0) begin : g_head
      assign a_src   = bus.a;
      assign b_chunk = b_eff[W-1:0];
      assign c_src   = c0;
      assign v_src   = bus.in_valid;
    end else begin : g_body
      assign a_src   = a_q[k-1];
      assign b_chunk = b_q[k-1][W-1:0];
      assign c_src   = c_q[k-1];
      assign v_src   = v_q[k-1];
    end

    rca_chunk #(.W(W)) u_chunk (
      .a        (a_src[W-1:0]),
      .b        (b_chunk),
      .ci       (c_src),
      .s        (s),
      .co       (co),
      .c_msb_in (c_msb)
    );

    if (STAGES == 1) begin : g_flat
      assign a_nxt = s;
    end else begin : g_rot
      assign a_nxt = {s, a_src[G-1:W]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
      end else if (adv) begin
        v_q[k] <= v_src;
        c_q[k] <= co;
        a_q[k] <= a_nxt;
      end
    end

    // B only needs to travel as far as the stage that consumes its top chunk.
    if (k < STAGES - 1) begin : g_bpipe
      logic [G-1:0] b_src;
      if (k == 0) begin : g_bhead
        assign b_src = b_eff;
      end else begin : g_bbody
        assign b_src = b_q[k-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          b_q[k] <= '0;
        end else if (adv) begin
          b_q[k] <= {b_src[W-1:0], b_src[G-1:W]};
        end
      end
    end

    // Signed overflow is only meaningful at the top bit of the whole word.
    if (k == STAGES - 1) begin : g_tail
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= c_msb ^ co;
        end
      end
    end else begin : g_inner
      logic c_msb_unused;
      assign c_msb_unused = c_msb;
    end
  end

endmodule

// File: tb/tb_rca_pipe.sv
// Scoreboard bench for rca_pipe (G=128, STAGES=4): the driver pushes the
// reference result on every accept, the monitor pops on every emitted result.
module tb_rca_pipe;
  import rca_pipe_pkg::*;

  localparam int G  = 128;
  localparam int ST = 4;
  localparam int XW = G + 4;

  typedef logic [XW-1:0] xw_t;

  typedef struct {
    logic [G-1:0] sum;
    logic         carry;
    logic         ovf;
    int           acc;
    bit           lat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_issued  = 0;
  int   n_recv    = 0;
  int   n_flushed = 0;
  bit   stop_rand = 0;
  exp_t q[$];

  rca_pipe_if #(.G(G)) bus ();

  rca_pipe #(.G(G), .STAGES(ST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input xw_t act, input xw_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on widened operands.
  function automatic exp_t model(input logic [G-1:0] a, input logic [G-1:0] b,
                                 input logic cin, input logic sub);
    exp_t e;
    logic [G+1:0]        ua;
    logic signed [G+1:0] sa, sb, sc, sr, smax, smin;
    sa   = $signed({{2{a[G-1]}}, a});
    sb   = $signed({{2{b[G-1]}}, b});
    sc   = $signed((G+2)'(cin));
    smax = $signed({3'b000, {(G-1){1'b1}}});
    smin = $signed({3'b111, {(G-1){1'b0}}});
    if (!sub) begin
      ua      = {2'b00, a} + {2'b00, b} + (G+2)'(cin);
      e.carry = ua[G];
      sr      = sa + sb + sc;
    end else begin
      ua      = {2'b00, a} - {2'b00, b} - (G+2)'(cin);
      e.carry = ({1'b0, a} >= ({1'b0, b} + (G+1)'(cin)));
      sr      = sa - sb - sc;
    end
    e.sum = ua[G-1:0];
    e.ovf = (sr > smax) || (sr < smin);
    e.acc = 0;
    e.lat = 0;
    return e;
  endfunction

  function automatic logic [G-1:0] rnd();
    logic [G-1:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0:       r = '1;
      1:       r = '0;
      2:       r = {1'b0, {(G-1){1'b1}}};
      3:       r = {1'b1, {(G-1){1'b0}}};
      default: ;
    endcase
    return r;
  endfunction

  task automatic issue(input logic [G-1:0] ta, input logic [G-1:0] tb_v,
                       input logic tc, input logic ts, input bit lat);
    exp_t e;
    int   tries;
    tries = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a   = ta;
    bus.b   = tb_v;
    bus.cin = tc;
    bus.sub = ts;
    forever begin
      #1;
      if (bus.in_ready) break;
      tries++;
      if (tries > 100) begin
        total++;
        bad++;
        $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles", tries);
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    e     = model(ta, tb_v, tc, ts);
    e.acc = cyc;
    e.lat = lat;
    q.push_back(e);
    n_issued++;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("drain_pending", xw_t'(q.size()), xw_t'(0));
  endtask

  // Monitor: pops on every handshaken result and checks held outputs during stalls.
  initial begin : monitor
    exp_t e;
    logic hold;
    xw_t  snap;
    hold = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold)
          chk("stall_hold", xw_t'({bus.out_valid, bus.sum, bus.carry, bus.ovf}), snap);
        chk("in_ready", xw_t'(bus.in_ready), xw_t'(!bus.out_valid || bus.out_ready));
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: sum=%0h with nothing outstanding", bus.sum);
          end else begin
            e = q.pop_front();
            chk("sum",   xw_t'(bus.sum),   xw_t'(e.sum));
            chk("carry", xw_t'(bus.carry), xw_t'(e.carry));
            chk("ovf",   xw_t'(bus.ovf),   xw_t'(e.ovf));
            if (e.lat) chk("latency", xw_t'(cyc - e.acc), xw_t'(ST));
            n_recv++;
          end
        end
        hold = bus.out_valid && !bus.out_ready;
        snap = xw_t'({bus.out_valid, bus.sum, bus.carry, bus.ovf});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", xw_t'(bus.out_valid), xw_t'(0));
    chk("rst_sum",       xw_t'(bus.sum),       xw_t'(0));
    chk("rst_carry",     xw_t'(bus.carry),     xw_t'(0));
    chk("rst_ovf",       xw_t'(bus.ovf),       xw_t'(0));
    chk("rst_in_ready",  xw_t'(bus.in_ready),  xw_t'(1));
    rst_n = 1'b1;

    // Single ops with exact latency checks.
    issue(G'(32'hFFFF_FFFF), G'(1), 1'b0, MODE_ADD, 1); idle(); drain();
    issue('1, '0, 1'b1, MODE_ADD, 1); idle(); drain();
    issue(G'(5), G'(7), 1'b0, MODE_SUB, 1);
    issue(G'(7), G'(5), 1'b0, MODE_SUB, 1); idle(); drain();
    issue({1'b0, {(G-1){1'b1}}}, G'(1), 1'b0, MODE_ADD, 1);
    issue({1'b1, {(G-1){1'b0}}}, G'(1), 1'b0, MODE_SUB, 1);
    issue('1, '1, 1'b1, MODE_ADD, 1);
    issue(G'(0), G'(0), 1'b1, MODE_SUB, 1);
    issue(G'(9), G'(9), 1'b0, MODE_SUB, 1); idle(); drain();

    // Back-to-back random burst with a 3-cycle downstream stall.
    fork
      begin
        for (int i = 0; i < 8; i++)
          issue(rnd(), rnd(), 1'($urandom()), 1'($urandom()), 0);
        idle();
      end
      begin
        repeat (5) @(negedge clk);
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic under random backpressure.
    stop_rand = 0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          issue(rnd(), rnd(), 1'($urandom()), 1'($urandom()), 0);
        idle();
        stop_rand = 1;
      end
      begin
        while (!stop_rand) begin
          @(negedge clk);
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    bus.out_ready = 1'b1;
    drain();

    // Reset with three operations in flight: all of them must vanish.
    issue(rnd(), rnd(), 1'b0, MODE_ADD, 1);
    issue(rnd(), rnd(), 1'b1, MODE_SUB, 1);
    issue(rnd(), rnd(), 1'b0, MODE_ADD, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    n_flushed += q.size();
    q.delete();
    #1;
    chk("midrst_out_valid", xw_t'(bus.out_valid), xw_t'(0));
    chk("midrst_sum",       xw_t'(bus.sum),       xw_t'(0));
    chk("midrst_carry",     xw_t'(bus.carry),     xw_t'(0));
    chk("midrst_ovf",       xw_t'(bus.ovf),       xw_t'(0));
    @(posedge clk);
    #1;
    chk("midrst_edge_valid", xw_t'(bus.out_valid), xw_t'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", xw_t'(bus.in_ready), xw_t'(1));
    repeat (6) @(negedge clk);
    issue(G'(32'hFFFF_FFFF), G'(1), 1'b0, MODE_ADD, 1); idle(); drain();

    chk("result_count", xw_t'(n_recv), xw_t'(n_issued - n_flushed));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
